// File: rtl/pu_msp430_ram_master_pkg.sv
// Shared types and constants for the MSP430-style single-port RAM initiator.
package pu_msp430_ram_master_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StCapture,
        StResp,
        StClear
    } state_e;

    localparam logic [1:0] WEN_NONE = 2'b11;
    localparam logic [1:0] WEN_WORD = 2'b00;
    localparam logic       CEN_OFF  = 1'b1;

endpackage

// File: rtl/pu_msp430_ram_master_if.sv
// Request/response channels plus active-low RAM port of the RAM initiator.
interface pu_msp430_ram_master_if #(
    parameter int unsigned ADDR_MSB = 6
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_be;
    logic [ADDR_MSB:0] req_addr;
    logic [15:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [15:0]       rsp_rdata;
    logic              err_addr;
    logic              init_done;
    logic [ADDR_MSB:0] ram_addr;
    logic              ram_cen;
    logic [1:0]        ram_wen;
    logic [15:0]       ram_din;
    logic [15:0]       ram_dout;

    // The controller side.
    modport master (
        input  req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready, ram_dout,
        output req_ready, rsp_valid, rsp_rdata, err_addr, init_done,
               ram_addr, ram_cen, ram_wen, ram_din
    );

    // Traffic generator and RAM side.
    modport slave (
        output req_valid, req_we, req_be, req_addr, req_wdata, rsp_ready, ram_dout,
        input  req_ready, rsp_valid, rsp_rdata, err_addr, init_done,
               ram_addr, ram_cen, ram_wen, ram_din
    );

endinterface

// File: rtl/pu_msp430_ram_master.sv
// Valid/ready to single-port RAM initiator with one-cycle registered read.
// Optional power-up clear walk enabled by PU_MSP430_RAM_MASTER_CLEAR_EN.
module pu_msp430_ram_master
    import pu_msp430_ram_master_pkg::*;
#(
    parameter int unsigned ADDR_MSB = 6,
    parameter int unsigned MEM_SIZE = 256
) (
    input  logic                          mclk,
    input  logic                          puc_rst,
    pu_msp430_ram_master_if.master        bus_io
);

    localparam int unsigned Words = MEM_SIZE / 2;

    state_e            state_q;
    logic              we_q;
    logic              ram_cen_q;
    logic [1:0]        ram_wen_q;
    logic [ADDR_MSB:0] ram_addr_q;
    logic [15:0]       ram_din_q;
    logic              rsp_valid_q;
    logic [15:0]       rsp_rdata_q;
    logic              err_addr_q;
    logic              init_done;
    logic              accept;
    logic              addr_oor;

`ifdef PU_MSP430_RAM_MASTER_CLEAR_EN
    logic              init_done_q;
    logic [ADDR_MSB+1:0] clr_cnt_q;
    assign init_done = init_done_q;
`else
    assign init_done = 1'b1;
`endif

    assign bus_io.req_ready = (state_q == StIdle) && init_done && !rsp_valid_q;
    assign accept           = bus_io.req_valid && bus_io.req_ready;
    assign addr_oor         = 32'(bus_io.req_addr) >= Words;

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
`ifdef PU_MSP430_RAM_MASTER_CLEAR_EN
            state_q     <= StClear;
            init_done_q <= 1'b0;
            clr_cnt_q   <= '0;
`else
            state_q     <= StIdle;
`endif
            we_q        <= 1'b0;
            ram_cen_q   <= CEN_OFF;
            ram_wen_q   <= WEN_NONE;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            err_addr_q  <= 1'b0;
        end else begin
            err_addr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (addr_oor) begin
                            // No RAM cycle; a read still gets a zero response.
                            err_addr_q <= 1'b1;
                            if (!bus_io.req_we) begin
                                rsp_rdata_q <= '0;
                                rsp_valid_q <= 1'b1;
                                state_q     <= StResp;
                            end
                        end else if (!bus_io.req_we) begin
                            we_q       <= 1'b0;
                            ram_addr_q <= bus_io.req_addr;
                            ram_wen_q  <= WEN_NONE;
                            ram_cen_q  <= 1'b0;
                            state_q    <= StAccess;
                        end else if (bus_io.req_be != 2'b00) begin
                            we_q       <= 1'b1;
                            ram_addr_q <= bus_io.req_addr;
                            ram_din_q  <= bus_io.req_wdata;
                            ram_wen_q  <= ~bus_io.req_be;
                            ram_cen_q  <= 1'b0;
                            state_q    <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    ram_cen_q <= CEN_OFF;
                    ram_wen_q <= WEN_NONE;
                    state_q   <= we_q ? StIdle : StCapture;
                end
                StCapture: begin
                    rsp_rdata_q <= bus_io.ram_dout;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StResp: begin
                    if (bus_io.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                StClear: begin
`ifdef PU_MSP430_RAM_MASTER_CLEAR_EN
                    if (32'(clr_cnt_q) < Words) begin
                        ram_cen_q  <= 1'b0;
                        ram_wen_q  <= WEN_WORD;
                        ram_din_q  <= '0;
                        ram_addr_q <= clr_cnt_q[ADDR_MSB:0];
                        clr_cnt_q  <= clr_cnt_q + 1'b1;
                    end else begin
                        ram_cen_q   <= CEN_OFF;
                        ram_wen_q   <= WEN_NONE;
                        init_done_q <= 1'b1;
                        state_q     <= StIdle;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus_io.ram_cen   = ram_cen_q;
    assign bus_io.ram_wen   = ram_wen_q;
    assign bus_io.ram_addr  = ram_addr_q;
    assign bus_io.ram_din   = ram_din_q;
    assign bus_io.rsp_valid = rsp_valid_q;
    assign bus_io.rsp_rdata = rsp_rdata_q;
    assign bus_io.err_addr  = err_addr_q;
    assign bus_io.init_done = init_done;

endmodule

// File: tb/tb_pu_msp430_ram_master.sv
// Randomized bench for pu_msp430_ram_master against a transaction-level model.
module tb_pu_msp430_ram_master;

    localparam int Words = 128;

    logic mclk;
    logic puc_rst;
    logic ram_init;
    bit   rr_rand;

    pu_msp430_ram_master_if #(.ADDR_MSB(7)) bus ();

    pu_msp430_ram_master #(.ADDR_MSB(7), .MEM_SIZE(256)) dut (
        .mclk    (mclk),
        .puc_rst (puc_rst),
        .bus_io  (bus.master)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] seed_val(input int i);
        return 16'((i * 40503 + 7) ^ (i << 9));
    endfunction

    // Behavioural single-port RAM: active-low controls, registered read.
    logic [15:0] ram [256];
    always @(posedge mclk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= seed_val(i);
        end else if (bus.ram_cen === 1'b0) begin
            if (!bus.ram_wen[0]) ram[bus.ram_addr][7:0]  <= bus.ram_din[7:0];
            if (!bus.ram_wen[1]) ram[bus.ram_addr][15:8] <= bus.ram_din[15:8];
            bus.ram_dout <= ram[bus.ram_addr];
        end
    end

    // Transaction-level model: expected memory image plus countdowns to readiness/response.
    logic [15:0] gold [256];
    bit          chk_en = 0;
    bit          m_acc  = 0;
    bit          e_rdy  = 0;
    bit          e_err  = 0;
    bit          e_cen  = 1;
    bit          e_init = 0;
    bit          rsp_v  = 0;
    logic [15:0] rsp_d  = '0;
    logic [7:0]  e_addr = '0;
    logic [1:0]  e_wen  = 2'b11;
    logic [15:0] e_din  = '0;
    int          busy   = 0;
    int          rsp_cnt = 0;
    bit          clr_on = 0;
    int          clr_idx = 0;

    always @(posedge mclk) begin
        m_acc = 0;
        if (puc_rst) begin
            chk_en  = 1;
            busy    = 0;
            rsp_cnt = 0;
            rsp_v   = 0;
            e_err   = 0;
            e_cen   = 1;
`ifdef PU_MSP430_RAM_MASTER_CLEAR_EN
            clr_on  = 1;
            clr_idx = 0;
            e_init  = 0;
`else
            e_init  = 1;
`endif
        end else begin
            e_err = 0;
            e_cen = 1;
            if (rsp_v && bus.rsp_ready) rsp_v = 0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) rsp_v = 1;
            end
            if (busy > 0) busy--;
            if (clr_on) begin
                if (clr_idx < Words) begin
                    e_cen  = 0;
                    e_addr = 8'(clr_idx);
                    e_wen  = 2'b00;
                    e_din  = 16'h0000;
                    gold[clr_idx] = 16'h0000;
                    clr_idx++;
                end else begin
                    clr_on = 0;
                    e_init = 1;
                end
            end else if (bus.req_valid && e_rdy) begin
                m_acc = 1;
                if (int'(bus.req_addr) >= Words) begin
                    e_err = 1;
                    if (!bus.req_we) begin
                        rsp_v = 1;
                        rsp_d = 16'h0000;
                    end
                end else if (!bus.req_we) begin
                    e_cen   = 0;
                    e_addr  = bus.req_addr;
                    e_wen   = 2'b11;
                    rsp_cnt = 2;
                    rsp_d   = gold[bus.req_addr];
                end else if (bus.req_be != 2'b00) begin
                    e_cen  = 0;
                    e_addr = bus.req_addr;
                    e_wen  = ~bus.req_be;
                    e_din  = bus.req_wdata;
                    busy   = 1;
                    if (bus.req_be[0]) gold[bus.req_addr][7:0]  = bus.req_wdata[7:0];
                    if (bus.req_be[1]) gold[bus.req_addr][15:8] = bus.req_wdata[15:8];
                end
            end
        end
        e_rdy = !clr_on && e_init && busy == 0 && rsp_cnt == 0 && !rsp_v;
    end

    always @(negedge mclk) begin
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(rsp_v));
            if (rsp_v) chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(rsp_d));
            chk("err_addr", 32'(bus.err_addr), 32'(e_err));
            chk("init_done", 32'(bus.init_done), 32'(e_init));
            chk("ram_cen", 32'(bus.ram_cen), 32'(e_cen));
            if (!e_cen) begin
                chk("ram_addr", 32'(bus.ram_addr), 32'(e_addr));
                chk("ram_wen", 32'(bus.ram_wen), 32'(e_wen));
                if (e_wen != 2'b11) chk("ram_din", 32'(bus.ram_din), 32'(e_din));
            end
        end
    end

    initial begin
        forever begin
            @(posedge mclk);
            #1;
            if (rr_rand) bus.rsp_ready = $urandom_range(0, 3) != 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    // Present a request and hold it until the model sees it accepted.
    task automatic send(input bit we, input logic [1:0] be, input logic [7:0] addr,
                        input logic [15:0] wd);
        int n = 0;
        bus.req_we    = we;
        bus.req_be    = be;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        do begin
            @(posedge mclk);
            #1;
            n++;
        end while (!m_acc && n < 60);
        chk("accept_in_time", 32'(m_acc), 32'd1);
        bus.req_valid = 1'b0;
        bus.req_we    = 1'($urandom);
        bus.req_be    = 2'($urandom);
        bus.req_addr  = 8'($urandom);
        bus.req_wdata = 16'($urandom);
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            idle(1);
            lat++;
        end
    endtask

    task automatic wait_init();
        int n = 0;
        while (!bus.init_done && n < Words + 20) begin
            idle(1);
            n++;
        end
        chk("init_done_rise", 32'(bus.init_done), 32'd1);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 256; i++) gold[i] = seed_val(i);
        puc_rst       = 1'b1;
        ram_init      = 1'b1;
        rr_rand       = 0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_be    = 2'b00;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;
        idle(3);
        ram_init = 1'b0;
        chk("rst_ram_wen", 32'(bus.ram_wen), 32'h3);
        chk("rst_ram_addr", 32'(bus.ram_addr), 32'h0);
        chk("rst_ram_din", 32'(bus.ram_din), 32'h0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'h0);
        chk("rst_ram_cen", 32'(bus.ram_cen), 32'h1);
        puc_rst = 1'b0;
        wait_init();

`ifdef PU_MSP430_RAM_MASTER_CLEAR_EN
        send(1'b0, 2'b11, 8'h7F, 16'h0);
        wait_rsp(lat);
        chk("clear_rd7f", 32'(bus.rsp_rdata), 32'h0000);
        idle(1);
`endif

        // Full-word write then read back.
        send(1'b1, 2'b11, 8'h05, 16'hA55A);
        chk("wr_cen", 32'(bus.ram_cen), 32'h0);
        chk("wr_wen", 32'(bus.ram_wen), 32'h0);
        chk("wr_addr", 32'(bus.ram_addr), 32'h05);
        chk("wr_din", 32'(bus.ram_din), 32'hA55A);
        send(1'b0, 2'b11, 8'h05, 16'h0);
        chk("rd_wen", 32'(bus.ram_wen), 32'h3);
        wait_rsp(lat);
        chk("rd_latency", 32'(lat), 32'd2);
        chk("rd_a55a", 32'(bus.rsp_rdata), 32'hA55A);
        idle(1);

        // Byte-lane merges.
        send(1'b1, 2'b11, 8'h10, 16'h1234);
        send(1'b1, 2'b01, 8'h10, 16'hFFEE);
        chk("be01_wen", 32'(bus.ram_wen), 32'h2);
        send(1'b1, 2'b10, 8'h10, 16'hCDFF);
        chk("be10_wen", 32'(bus.ram_wen), 32'h1);
        send(1'b0, 2'b11, 8'h10, 16'h0);
        wait_rsp(lat);
        chk("rd_cdee", 32'(bus.rsp_rdata), 32'hCDEE);
        idle(1);

        // Zero byte enables: consumed without a RAM cycle.
        send(1'b1, 2'b00, 8'h20, 16'hBEEF);
        chk("be00_cen", 32'(bus.ram_cen), 32'h1);
        chk("be00_err", 32'(bus.err_addr), 32'h0);

        // Response backpressure.
        bus.rsp_ready = 1'b0;
        send(1'b0, 2'b11, 8'h05, 16'h0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("bp_valid", 32'(bus.rsp_valid), 32'h1);
            chk("bp_rdata", 32'(bus.rsp_rdata), 32'hA55A);
            chk("bp_ready", 32'(bus.req_ready), 32'h0);
            chk("bp_cen", 32'(bus.ram_cen), 32'h1);
        end
        bus.rsp_ready = 1'b1;
        idle(1);
        chk("bp_release", 32'(bus.rsp_valid), 32'h0);

        // Out-of-range read and write.
        send(1'b0, 2'b11, 8'h80, 16'h0);
        chk("oor_rd_err", 32'(bus.err_addr), 32'h1);
        chk("oor_rd_cen", 32'(bus.ram_cen), 32'h1);
        wait_rsp(lat);
        chk("oor_rd_lat", 32'(lat), 32'd0);
        chk("oor_rd_data", 32'(bus.rsp_rdata), 32'h0000);
        idle(1);
        chk("oor_err_pulse", 32'(bus.err_addr), 32'h0);
        send(1'b1, 2'b11, 8'h80, 16'h5555);
        chk("oor_wr_err", 32'(bus.err_addr), 32'h1);
        chk("oor_wr_cen", 32'(bus.ram_cen), 32'h1);
        idle(1);
        chk("oor_wr_norsp", 32'(bus.rsp_valid), 32'h0);

        // Reset one cycle after a read is accepted.
        send(1'b0, 2'b11, 8'h10, 16'h0);
        puc_rst = 1'b1;
        idle(1);
        puc_rst = 1'b0;
        chk("rst_abort_cen", 32'(bus.ram_cen), 32'h1);
        chk("rst_abort_rsp", 32'(bus.rsp_valid), 32'h0);
`ifndef PU_MSP430_RAM_MASTER_CLEAR_EN
        chk("rst_abort_ready", 32'(bus.req_ready), 32'h1);
`endif
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("rst_abort_norsp", 32'(bus.rsp_valid), 32'h0);
        end
        wait_init();

        // Randomized traffic with random response backpressure.
        rr_rand = 1;
        for (int t = 0; t < 400; t++) begin
            logic [7:0] a;
            if ($urandom_range(0, 7) == 0)      a = 8'($urandom_range(128, 255));
            else if ($urandom_range(0, 1) == 0) a = 8'($urandom_range(0, 15));
            else                                a = 8'($urandom_range(0, 127));
            idle($urandom_range(0, 2));
            send(1'($urandom), 2'($urandom), a, 16'($urandom));
        end
        rr_rand = 0;
        idle(1);
        bus.rsp_ready = 1'b1;
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
